lcd_msg_arbiter: RTL and testbench
==================================

LCD_MSG_ARBITER -- requirements
Module: lcd_msg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of message requesters, fixed at 4 for this revision.
REQ-002 Parameter DWELL_CYCLES, default 50000000: minimum CLOCK_50 cycles a message stays displayed before re-arbitration (26-bit counter).
REQ-003 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester display request, level-sensitive.
REQ-006 msg  input  1024  four packed 32-char messages; requester i occupies bits [256i+255:256i]; char k at [256i+8k+7:256i+8k]; k 0-15 line 0, k 16-31 line 1.
REQ-007 characters  output  8 x [1:0][15:0]  display buffer in the LCD driver's characters layout.
REQ-008 grant  output  4  one-hot owner of the copy in progress; all-zero otherwise.
REQ-009 ack  output  4  one-hot, one-cycle pulse: requester's message fully copied.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, COPY and DWELL.
REQ-012 IDLE: with any req bit high at an edge, the block SHALL register grant for the winner, clear idx (5-bit) and enter COPY on that edge.
REQ-013 Winner selection SHALL be round-robin: search starts at last_grant+1 modulo 4; last_grant updates to the winner.
REQ-014 COPY: each edge SHALL write characters[idx[4]][idx[3:0]] from the granted requester's char idx, then increment idx.
REQ-015 The edge writing idx=31 SHALL clear grant, pulse ack for the granted requester for exactly one cycle, load dwell counter with DWELL_CYCLES-1 and enter DWELL.
REQ-016 With DWELL_CYCLES=0, that edge SHALL enter IDLE directly; ack is unchanged.
REQ-017 DWELL: the counter SHALL decrement each edge; at 0 the block SHALL enter IDLE on the next edge.
REQ-018 Latency: req sampled at edge E0; grant high after E0; writes at E1..E32; ack high between E32 and E33; earliest next grant at E33+DWELL_CYCLES.
REQ-019 Deassertion of req during COPY or DWELL SHALL NOT abort the copy; the copy SHALL complete and ack SHALL still pulse.
REQ-020 Requesters SHALL hold msg stable from request until ack; the block samples msg live and does not latch the message.
REQ-021 A req held high after its ack SHALL be treated as a new request in the next IDLE, subject to round-robin order.
REQ-022 Requests arriving in COPY or DWELL SHALL wait; they SHALL NOT be lost or queued beyond req level.
REQ-023 characters SHALL change only during COPY and hold their value in IDLE and DWELL.

Reset
REQ-024 Reset low SHALL immediately force IDLE, grant=0, ack=0, busy=0, idx=0, dwell counter=0, last_grant=3, and every characters byte to 8'h20 (space).
REQ-025 Reset asserted mid-COPY SHALL abandon the copy without an ack; the buffer SHALL be all spaces.
REQ-026 After Reset deasserts, the first arbitration SHALL favour requester 0.

Verification (DWELL_CYCLES=8 unless noted)
REQ-027 Reset pulse -> all 32 characters = 8'h20; grant=0, ack=0, busy=0.
REQ-028 req=4'b0100 at E0, msg2 = "HELLO WORLD     " / "SCORE 0042      " -> grant=4'b0100 after E0; characters[0][0]=8'h48 after E1; characters[1][15]=8'h20 after E32; ack=4'b0100 for one cycle after E32; busy low after E41.
REQ-029 req=4'b1111 held -> grant order 0,1,2,3,0; consecutive grants 41 cycles apart.
REQ-030 req=4'b0001 dropped after E3 -> copy completes; ack=4'b0001 after E32.
REQ-031 Reset low after E10 of a copy -> busy=0 at once, no ack, buffer all spaces; next req=4'b0010 granted normally.
REQ-032 DWELL_CYCLES=0, req=4'b0011 held -> grant 0 then grant 1 on the edge after ack 0 (33-cycle spacing).

Source files
------------

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter that copies one requester's 32-character message into the
// LCD display buffer, then holds it on screen for a dwell period before re-arbitrating.
module lcd_msg_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic                       CLOCK_50,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*256-1:0]       msg,
  output logic [1:0][15:0][7:0]      characters,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam logic [25:0] DWELL_LOAD = (DWELL_CYCLES == 0) ? 26'd0 : 26'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COPY, DWELL} state_t;

  state_t            state, state_n;
  logic [N_REQ-1:0]  grant_n, ack_n;
  logic [4:0]        idx, idx_n;
  logic [25:0]       cnt, cnt_n;
  logic [OW-1:0]     last_grant, last_n;
  logic [OW-1:0]     owner, owner_n;
  logic [OW-1:0]     cand, win;
  logic              found;
  int unsigned       probe;
  logic [7:0]        char_byte;

  assign busy      = (state != IDLE);
  assign char_byte = msg[{owner, idx, 3'b000} +: 8];

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      grant      <= '0;
      ack        <= '0;
      idx        <= '0;
      cnt        <= '0;
      last_grant <= OW'(N_REQ - 1);
      owner      <= '0;
      characters <= {32{8'h20}};
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      ack        <= ack_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
      owner      <= owner_n;
      if (state == COPY) characters[idx[4]][idx[3:0]] <= char_byte;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ack_n   = '0;
    idx_n   = idx;
    cnt_n   = cnt;
    last_n  = last_grant;
    owner_n = owner;
    found   = 1'b0;
    win     = '0;
    probe   = 0;
    cand    = '0;

    // First requester found scanning from last_grant+1 wins.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      probe = (32'(last_grant) + i) % N_REQ;
      cand  = OW'(probe);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n      = '0;
          grant_n[win] = 1'b1;
          owner_n      = win;
          last_n       = win;
          idx_n        = '0;
          state_n      = COPY;
        end
      end
      COPY: begin
        idx_n = idx + 5'd1;
        if (idx == 5'd31) begin
          grant_n = '0;
          ack_n   = grant;
          if (DWELL_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = DWELL_LOAD;
            state_n = DWELL;
          end
        end
      end
      DWELL: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 26'd1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed bench for lcd_msg_arbiter: table of single-request transactions plus
// round-robin, mid-copy reset and zero-dwell sequences.
module tb_lcd_msg_arbiter;

  logic                  CLOCK_50 = 1'b0;
  logic                  Reset;
  logic [3:0]            req, req0;
  logic [1023:0]         msg;
  logic [1:0][15:0][7:0] characters, characters0;
  logic [3:0]            grant, ack, grant0, ack0;
  logic                  busy, busy0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string line0[4];
  string line1[4];

  typedef struct {
    logic [3:0] req;
    int         drop_after;
    logic [3:0] grant;
    int         owner;
  } vec_t;
  vec_t tbl[4];

  logic [3:0] gseen[8];
  int         tseen[8];

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  lcd_msg_arbiter #(.N_REQ(4), .DWELL_CYCLES(8)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .req(req), .msg(msg),
    .characters(characters), .grant(grant), .ack(ack), .busy(busy)
  );

  lcd_msg_arbiter #(.N_REQ(4), .DWELL_CYCLES(0)) dut0 (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .req(req0), .msg(msg),
    .characters(characters0), .grant(grant0), .ack(ack0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int r, input int k);
    string s;
    int    p;
    s = (k < 16) ? line0[r] : line1[r];
    p = k % 16;
    return (p < s.len()) ? s[p] : 8'h20;
  endfunction

  task automatic load_msgs();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 32; k++)
        msg[256*r + 8*k +: 8] = exp_char(r, k);
  endtask

  // r < 0 means the buffer must be all spaces
  task automatic buf_check(input string name, input int r);
    int         bad;
    logic [7:0] e;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      e = (r < 0) ? 8'h20 : exp_char(r, k);
      if (characters[k/16][k%16] !== e) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || busy0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    line0[0] = "PLAYER ONE";     line1[0] = "READY";
    line0[1] = "TEMP 23C";       line1[1] = "HUMID 41%";
    line0[2] = "HELLO WORLD";    line1[2] = "SCORE 0042";
    line0[3] = "ALARM 07:30";    line1[3] = "SNOOZE? Y/N";
    tbl[0] = '{req: 4'b0100, drop_after: 32, grant: 4'b0100, owner: 2};
    tbl[1] = '{req: 4'b0001, drop_after: 3,  grant: 4'b0001, owner: 0};
    tbl[2] = '{req: 4'b1010, drop_after: 32, grant: 4'b0010, owner: 1};
    tbl[3] = '{req: 4'b1010, drop_after: 32, grant: 4'b1000, owner: 3};

    req = '0; req0 = '0; msg = '0; Reset = 1'b0;
    load_msgs();
    tick(); tick();
    buf_check("reset_buffer", -1);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_ack", ack, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    Reset = 1'b1;
    tick();

    // All requesters held: round-robin order from requester 0, 41-cycle spacing.
    begin
      logic [3:0] prevg;
      int         n;
      prevg = '0; n = 0;
      req = 4'b1111;
      for (int c = 0; c < 400 && n < 5; c++) begin
        tick();
        if (grant != 0 && prevg == 0) begin
          gseen[n] = grant; tseen[n] = cyc; n++;
        end
        prevg = grant;
      end
      req = '0;
      chk("rr_count", n, 5);
      chk("rr_g0", gseen[0], 4'b0001);
      chk("rr_g1", gseen[1], 4'b0010);
      chk("rr_g2", gseen[2], 4'b0100);
      chk("rr_g3", gseen[3], 4'b1000);
      chk("rr_g4", gseen[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("rr_spacing", tseen[i] - tseen[i-1], 41);
    end
    wait_idle();

    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      req = tbl[v].req;
      tick();
      chk("tx_grant", grant, tbl[v].grant);
      chk("tx_busy", busy, 1'b1);
      for (int c = 1; c <= 32; c++) begin
        tick();
        if (c == tbl[v].drop_after || c == 32) req = '0;
        if (c == 1) chk("tx_first_char", characters[0][0], exp_char(tbl[v].owner, 0));
        if (c == 31) chk("tx_ack_early", ack, 4'b0000);
      end
      chk("tx_ack", ack, tbl[v].grant);
      chk("tx_grant_clear", grant, 4'b0000);
      chk("tx_last_char", characters[1][15], exp_char(tbl[v].owner, 31));
      buf_check("tx_buffer", tbl[v].owner);
      msg = '1;
      tick();
      chk("tx_ack_pulse", ack, 4'b0000);
      chk("tx_dwell_busy", busy, 1'b1);
      for (int c = 34; c <= 41; c++) tick();
      chk("tx_idle", busy, 1'b0);
      buf_check("tx_hold", tbl[v].owner);
      load_msgs();
    end

    // Reset in the middle of a copy abandons it without an ack.
    wait_idle();
    req = 4'b0001;
    tick();
    chk("mid_grant", grant, 4'b0001);
    for (int c = 1; c <= 10; c++) tick();
    Reset = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_grant_clear", grant, 4'b0000);
    chk("mid_ack", ack, 4'b0000);
    buf_check("mid_buffer", -1);
    req = '0;
    tick(); tick();
    chk("mid_no_ack", ack, 4'b0000);
    Reset = 1'b1;
    req = 4'b0010;
    tick();
    chk("post_grant", grant, 4'b0010);
    for (int c = 1; c <= 32; c++) tick();
    req = '0;
    chk("post_ack", ack, 4'b0010);
    buf_check("post_buffer", 1);
    wait_idle();

    // Zero dwell: back-to-back grants 33 cycles apart, ack just before the second.
    begin
      logic [3:0] prevg;
      int         n;
      int         tack;
      prevg = '0; n = 0; tack = -1;
      req0 = 4'b0011;
      for (int c = 0; c < 200 && n < 2; c++) begin
        tick();
        if (ack0 == 4'b0001 && tack < 0) tack = cyc;
        if (grant0 != 0 && prevg == 0) begin
          gseen[n] = grant0; tseen[n] = cyc; n++;
        end
        prevg = grant0;
      end
      req0 = '0;
      chk("z_count", n, 2);
      chk("z_g0", gseen[0], 4'b0001);
      chk("z_g1", gseen[1], 4'b0010);
      chk("z_spacing", tseen[1] - tseen[0], 33);
      chk("z_ack_cycle", tack, tseen[1] - 1);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
